uart_reg_responder: RTL and testbench



---
 rtl/uart_reg_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_reg_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_responder.sv
// Byte-command responder for a UART host link: decodes write (0x57) / read (0x52) commands
// into an 8-bit register file and returns one response byte per command. Macro: UART_RESP_CHECKSUM_EN.
module uart_reg_responder #(
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [7:0]                       rx_data_i,
  input  logic                             rx_ready_i,
  output logic                             tx_start_o,
  output logic [7:0]                       tx_data_o,
  input  logic                             tx_busy_i,
  output logic [8*(1 << ADDR_WIDTH)-1:0]   regs_o,
  output logic                             cmd_error_o,
  output logic                             overrun_o
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
  localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  // States with bit 2 set are the non-accepting response phase.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GET_ADDR = 3'd1;
  localparam logic [2:0] S_GET_DATA = 3'd2;
`ifdef UART_RESP_CHECKSUM_EN
  localparam logic [2:0] S_GET_SUM  = 3'd3;
`endif
  localparam logic [2:0] S_EXEC     = 3'd4;
  localparam logic [2:0] S_SEND     = 3'd5;
  localparam logic [2:0] S_WAIT_HI  = 3'd6;
  localparam logic [2:0] S_WAIT_LO  = 3'd7;

  logic [2:0]                 state_q, state_d;
  logic                       is_wr_q, is_wr_d;
  logic [7:0]                 addr_q, addr_d;
  logic [7:0]                 data_q, data_d;
  logic                       nak_q, nak_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       tx_start_q, tx_start_d;
  logic                       cmd_error_q, cmd_error_d;
  logic                       overrun_q, overrun_d;
`ifdef UART_RESP_CHECKSUM_EN
  logic [7:0]                 sum_q, sum_d;
`endif
  logic                       in_get_c;

  function automatic logic addr_ok(input logic [7:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  assign in_get_c = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA)
`ifdef UART_RESP_CHECKSUM_EN
                    || (state_q == S_GET_SUM)
`endif
                    ;

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    nak_d       = nak_q;
    tmo_d       = '0;
    regs_d      = regs_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    cmd_error_d = 1'b0;
    overrun_d   = overrun_q;
`ifdef UART_RESP_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_ready_i) begin
`ifdef UART_RESP_CHECKSUM_EN
          sum_d = rx_data_i;
`endif
          if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
            is_wr_d = (rx_data_i == OP_WRITE);
            nak_d   = 1'b0;
            state_d = S_GET_ADDR;
          end else begin
            nak_d       = 1'b1;
            cmd_error_d = 1'b1;
            state_d     = S_EXEC;
          end
        end
      end

      S_GET_ADDR: begin
        if (rx_ready_i) begin
          addr_d = rx_data_i;
`ifdef UART_RESP_CHECKSUM_EN
          sum_d  = sum_q ^ rx_data_i;
          state_d = is_wr_q ? S_GET_DATA : S_GET_SUM;
`else
          if (is_wr_q) begin
            state_d = S_GET_DATA;
          end else begin
            nak_d       = !addr_ok(rx_data_i);
            cmd_error_d = nak_d;
            state_d     = S_EXEC;
          end
`endif
        end
      end

      S_GET_DATA: begin
        if (rx_ready_i) begin
          data_d = rx_data_i;
`ifdef UART_RESP_CHECKSUM_EN
          sum_d   = sum_q ^ rx_data_i;
          state_d = S_GET_SUM;
`else
          nak_d       = !addr_ok(addr_q);
          cmd_error_d = nak_d;
          state_d     = S_EXEC;
`endif
        end
      end

`ifdef UART_RESP_CHECKSUM_EN
      S_GET_SUM: begin
        if (rx_ready_i) begin
          nak_d       = !addr_ok(addr_q) || (rx_data_i != sum_q);
          cmd_error_d = nak_d;
          state_d     = S_EXEC;
        end
      end
`endif

      S_EXEC: begin
        if (is_wr_q && !nak_q) begin
          regs_d[addr_q[ADDR_WIDTH-1:0]] = data_q;
        end
        if (nak_q) begin
          tx_data_d = RSP_NAK;
        end else if (is_wr_q) begin
          tx_data_d = RSP_ACK;
        end else begin
          tx_data_d = regs_q[addr_q[ADDR_WIDTH-1:0]];
        end
        tx_start_d = !tx_busy_i;
        state_d    = S_SEND;
      end

      // tx_start_q high means the single request pulse is on the wire this cycle.
      S_SEND: begin
        if (tx_start_q) begin
          state_d = S_WAIT_HI;
        end else if (!tx_busy_i) begin
          tx_start_d = 1'b1;
        end
      end

      S_WAIT_HI: begin
        if (tx_busy_i) begin
          state_d = S_WAIT_LO;
        end
      end

      S_WAIT_LO: begin
        if (!tx_busy_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout: abandon the command silently apart from the error pulse.
    if (in_get_c && !rx_ready_i) begin
      if (tmo_q == TMO_LAST) begin
        cmd_error_d = 1'b1;
        state_d     = S_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (rx_ready_i && state_q[2]) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      nak_q       <= 1'b0;
      tmo_q       <= '0;
      regs_q      <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      cmd_error_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RESP_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      nak_q       <= nak_d;
      tmo_q       <= tmo_d;
      regs_q      <= regs_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      cmd_error_q <= cmd_error_d;
      overrun_q   <= overrun_d;
`ifdef UART_RESP_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign regs_o      = regs_q;
  assign cmd_error_o = cmd_error_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder; the bench plays both the UART receiver and transmitter.
module tb_uart_reg_responder;

  localparam int unsigned AW   = 3;
  localparam int unsigned TMO  = 20;
  localparam logic [7:0]  ACK  = 8'h06;
  localparam logic [7:0]  NAK  = 8'h15;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [63:0] regs;
  logic        cmd_error;
  logic        overrun;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_regs = '0;

  uart_reg_responder #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .rx_data_i   (rx_data),
    .rx_ready_i  (rx_ready),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .tx_busy_i   (tx_busy),
    .regs_o      (regs),
    .cmd_error_o (cmd_error),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Byte is sampled at the posedge after the drive; returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                          input int n);
    logic [7:0] s;
    s = op;
    send_byte(op);
    if (n > 1) begin
      send_byte(a);
      s = s ^ a;
    end
    if (n > 2) begin
      send_byte(d);
      s = s ^ d;
    end
`ifdef UART_RESP_CHECKSUM_EN
    if (n > 1) send_byte(s);
`endif
  endtask

  // Waits for tx_start, then plays a busy transmitter; optionally pushes a byte mid-response.
  task automatic get_resp(input string tag, input logic [7:0] exp_byte, input int exp_err,
                          input bit inject);
    int lat;
    int errs;
    lat  = 0;
    errs = 0;
    while (lat < 50) begin
      if (cmd_error) errs++;
      if (tx_start) break;
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "/tx_start"}, 64'(tx_start), 64'(1));
    check_eq({tag, "/latency"}, 64'(lat), 64'(1));
    check_eq({tag, "/tx_data"}, 64'(tx_data), 64'(exp_byte));
    tx_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) check_eq({tag, "/pulse_len"}, 64'(tx_start), 64'(0));
      if (cmd_error) errs++;
      rx_data  = 8'h52;
      rx_ready = inject && (k == 0);
    end
    rx_ready = 1'b0;
    check_eq({tag, "/tx_data_hold"}, 64'(tx_data), 64'(exp_byte));
    tx_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, "/cmd_error"}, 64'(errs), 64'(exp_err));
  endtask

  initial begin
    int first;
    int errs;
    int starts;

    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    tx_busy  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst/tx_start", 64'(tx_start), 64'(0));
    check_eq("rst/tx_data", 64'(tx_data), 64'(0));
    check_eq("rst/regs", regs, 64'(0));
    check_eq("rst/cmd_error", 64'(cmd_error), 64'(0));
    check_eq("rst/overrun", 64'(overrun), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    send_cmd(8'h57, 8'h02, 8'hA5, 3);
    get_resp("wr2", ACK, 0, 1'b0);
    exp_regs[23:16] = 8'hA5;
    check_eq("wr2/regs", regs, exp_regs);

    send_cmd(8'h52, 8'h02, 8'h00, 2);
    get_resp("rd2", 8'hA5, 0, 1'b0);
    check_eq("rd2/regs", regs, exp_regs);

    send_cmd(8'h41, 8'h00, 8'h00, 1);
    get_resp("badop", NAK, 1, 1'b0);
    send_cmd(8'h52, 8'h00, 8'h00, 2);
    get_resp("rd0", 8'h00, 0, 1'b0);

    send_cmd(8'h57, 8'h09, 8'h11, 3);
    get_resp("wr9", NAK, 1, 1'b0);
    check_eq("wr9/regs", regs, exp_regs);

    send_cmd(8'h57, 8'h07, 8'h5A, 3);
    get_resp("wr7", ACK, 0, 1'b0);
    exp_regs[63:56] = 8'h5A;
    check_eq("wr7/regs", regs, exp_regs);
    send_cmd(8'h52, 8'h07, 8'h00, 2);
    get_resp("rd7", 8'h5A, 0, 1'b0);
    send_cmd(8'h52, 8'h08, 8'h00, 2);
    get_resp("rd8", NAK, 1, 1'b0);

    // Timeout: error pulse TMO cycles after the last byte's acceptance, no response.
    send_byte(8'h57);
    send_byte(8'h01);
    first  = -1;
    errs   = 0;
    starts = 0;
    for (int i = 0; i < int'(TMO) + 6; i++) begin
      if (cmd_error) begin
        errs++;
        if (first < 0) first = i;
      end
      if (tx_start) starts++;
      @(negedge clk);
    end
    check_eq("tmo/errs", 64'(errs), 64'(1));
    check_eq("tmo/when", 64'(first), 64'(TMO));
    check_eq("tmo/starts", 64'(starts), 64'(0));
    check_eq("tmo/regs", regs, exp_regs);
    send_cmd(8'h52, 8'h01, 8'h00, 2);
    get_resp("rd1", 8'h00, 0, 1'b0);

    check_eq("ovr/before", 64'(overrun), 64'(0));
    send_cmd(8'h57, 8'h05, 8'h3C, 3);
    get_resp("wr5", ACK, 0, 1'b1);
    exp_regs[47:40] = 8'h3C;
    check_eq("ovr/set", 64'(overrun), 64'(1));
    send_cmd(8'h52, 8'h05, 8'h00, 2);
    get_resp("rd5", 8'h3C, 0, 1'b0);
    check_eq("ovr/sticky", 64'(overrun), 64'(1));
    check_eq("wr5/regs", regs, exp_regs);

`ifdef UART_RESP_CHECKSUM_EN
    send_byte(8'h57);
    send_byte(8'h03);
    send_byte(8'h7E);
    send_byte(8'h2A);
    get_resp("sum_ok", ACK, 0, 1'b0);
    exp_regs[31:24] = 8'h7E;
    check_eq("sum_ok/regs", regs, exp_regs);
    send_byte(8'h57);
    send_byte(8'h03);
    send_byte(8'h55);
    send_byte(8'h00);
    get_resp("sum_bad", NAK, 1, 1'b0);
    check_eq("sum_bad/regs", regs, exp_regs);
`endif

    // Reset mid-command clears everything and returns to opcode hunting.
    send_byte(8'h57);
    send_byte(8'h04);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_regs = '0;
    check_eq("mid_rst/regs", regs, exp_regs);
    check_eq("mid_rst/overrun", 64'(overrun), 64'(0));
    check_eq("mid_rst/tx_data", 64'(tx_data), 64'(0));
    send_cmd(8'h52, 8'h05, 8'h00, 2);
    get_resp("rd5_after_rst", 8'h00, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
